rr_arbiter_1hot: RTL and testbench
==================================

// Module: rr_arbiter_1hot
// PURPOSE
//   Round-robin arbiter with packet lock. It sits directly upstream of the one-hot mux:
//   - Arbitrates INPUTS valid/ready requesters.
//   - Drives a registered one-hot select (sel) straight into the mux sel port.
//   - Holds the grant until the winner's last beat is accepted downstream.
//   - Re-arbitrates with zero bubble between packets.
// PARAMETERS
//   INPUTS   2   number of requesters; legal range 2..32
//   ID_W     $clog2(INPUTS)   localparam, width of grant_id
// PORTS
//   clk        in   1        single clock, all state on posedge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   INPUTS   per-requester beat valid
//   in_last    in   INPUTS   per-requester last beat of packet (qualified by in_valid)
//   in_ready   out  INPUTS   per-requester accept = sel & {INPUTS{out_ready}}
//   sel        out  INPUTS   registered one-hot grant (all-zero when idle) -> mux sel
//   grant_id   out  ID_W     binary index of sel; 0 when idle
//   out_valid  out  1        |(in_valid & sel)
//   out_last   out  1        |(in_last & in_valid & sel)
//   out_ready  in   1        downstream accept
// BEHAVIOUR
//   - Reset (rst=1 at posedge): sel=0, grant_id=0, ptr=0, state=IDLE.
//     - Combinational outputs follow: out_valid=0, out_last=0, in_ready=0.
//     - Reset mid-packet abandons the packet; no beat is accepted in the reset cycle.
//   - States: IDLE (sel==0) and LOCKED (sel one-hot). sel is never multi-hot.
//   - Winner selection (combinational, next_win): first i with in_valid[i]=1, scanning
//     ptr, ptr+1, ..., ptr+INPUTS-1, all indices mod INPUTS.
//   - IDLE:
//     - If |in_valid is set: sel <= onehot(next_win), ptr <= next_win+1 mod INPUTS, go to LOCKED.
//     - Otherwise stay in IDLE.
//   - LOCKED:
//     - Transfer cycle = out_valid & out_ready.
//     - Release cycle = transfer & out_last.
//     - On release with any in_valid: sel <= onehot(next_win), with next_win evaluated
//       using the already-advanced ptr. The released requester therefore ranks last.
//       It can win again only if it is the sole requester. ptr advances past the new winner.
//     - On release with no in_valid: sel <= 0, go to IDLE.
//     - Otherwise sel holds. A granted requester that drops in_valid mid-packet keeps the grant.
//   - Latency:
//     - in_valid rises in IDLE cycle N -> sel valid in cycle N+1 -> first transfer no earlier than N+1.
//     - Back-to-back packets from different requesters: no idle cycle between the last beat
//       of one packet and the first beat of the next.
//   - Requesters obey valid/ready: once in_valid is asserted, it and the data stay stable until in_ready.
//   - Non-granted requesters always see in_ready=0.
//   - Single-beat packets (in_last=1 on the first beat) release in the same cycle they transfer.
//   - Simultaneous requests: resolved purely by ptr order; no fixed priority.
//   - ptr wraps from INPUTS-1 to 0.
//   - Assertions:
//     - $onehot0(sel) every cycle.
//     - grant_id == index of sel.
//     - No in_ready outside sel.
// TESTING
//   1. Reset: hold rst 3 cycles with all in_valid=1
//      -> sel=0, in_ready=0, out_valid=0 during reset; sel=4'b0001 on cycle 2 after release.
//   2. INPUTS=4, all four valid, single-beat, out_ready=1
//      -> sel sequence 0001,0010,0100,1000,0001; one beat per cycle, no bubbles.
//   3. Req0 sends a 3-beat packet while req1 is valid throughout
//      -> sel=0001 for exactly 3 transfers; sel=0010 on the cycle after last is accepted.
//   4. Backpressure: out_ready=0 for 5 cycles mid-packet
//      -> sel, grant_id and out_valid hold; in_ready=0; no beats lost or duplicated.
//   5. Only req2 valid, repeated single-beat packets
//      -> req2 re-wins each release, sel=0100 continuously, ptr cycles to 3.
//   6. Assert rst during beat 2 of a 4-beat packet
//      -> next cycle sel=0, ptr=0; after reset, arbitration restarts from requester 0.

Source files
------------

// File: rtl/rr_arbiter_1hot.sv
// rtl/rr_arbiter_1hot.sv - round-robin arbiter with packet lock driving a registered one-hot mux select
module rr_arbiter_1hot #(
  parameter  int INPUTS = 2,
  localparam int ID_W   = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INPUTS-1:0] in_valid,
  input  logic [INPUTS-1:0] in_last,
  output logic [INPUTS-1:0] in_ready,
  output logic [INPUTS-1:0] sel,
  output logic [ID_W-1:0]   grant_id,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   next_win;
  logic [ID_W-1:0]   ptr_adv;
  logic [INPUTS-1:0] win_1hot;
  logic [ID_W:0]     scan;
  logic              any_valid;
  logic              xfer;
  logic              release_pkt;

  // Scan from ptr upwards with wrap; the extra bit keeps ptr+k from overflowing before the wrap.
  always_comb begin
    next_win  = '0;
    any_valid = 1'b0;
    scan      = '0;
    for (int k = 0; k < INPUTS; k++) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(INPUTS)) scan = scan - (ID_W+1)'(INPUTS);
      if (!any_valid && in_valid[scan[ID_W-1:0]]) begin
        any_valid = 1'b1;
        next_win  = scan[ID_W-1:0];
      end
    end
  end

  assign ptr_adv  = (next_win == ID_W'(INPUTS-1)) ? '0 : next_win + 1'b1;
  assign win_1hot = {{(INPUTS-1){1'b0}}, 1'b1} << next_win;

  // Outputs are gated during reset so a beat in flight is dropped rather than accepted.
  assign in_ready    = rst ? '0 : (sel & {INPUTS{out_ready}});
  assign out_valid   = !rst && |(in_valid & sel);
  assign out_last    = !rst && |(in_last & in_valid & sel);
  assign xfer        = out_valid & out_ready;
  assign release_pkt = xfer & out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            sel      <= win_1hot;
            grant_id <= next_win;
            ptr      <= ptr_adv;
            state    <= LOCKED;
          end
        end
        default: begin
          if (release_pkt) begin
            if (any_valid) begin
              sel      <= win_1hot;
              grant_id <= next_win;
              ptr      <= ptr_adv;
            end else begin
              sel      <= '0;
              grant_id <= '0;
              state    <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(sel));
      assert ((sel == '0) ? (grant_id == '0) : sel[grant_id]);
      assert ((in_ready & ~sel) == '0);
      assert ((state == IDLE) == (sel == '0));
    end
  end

endmodule

// File: tb/tb_rr_arbiter_1hot.sv
// tb/tb_rr_arbiter_1hot.sv - directed bench for rr_arbiter_1hot with INPUTS=4
module tb_rr_arbiter_1hot;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_last = '0;
  logic [3:0] in_ready;
  logic [3:0] sel;
  logic [1:0] grant_id;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_1hot #(.INPUTS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .grant_id  (grant_id),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (sel !== 4'b0000 || in_ready !== 4'b0000 || out_valid !== 1'b0 || grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: sel=%b in_ready=%b out_valid=%b grant_id=%0d, expected 0000/0000/0/0",
                 i, sel, in_ready, out_valid, grant_id);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (sel !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: sel=%b grant_id=%0d, expected 0001/0", sel, grant_id);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_sel [5];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (sel !== exp_sel[i] || grant_id !== 2'(i % 4) || out_valid !== 1'b1 || in_ready !== exp_sel[i]) begin
        n_fail++;
        $display("FAIL rotation[%0d]: sel=%b grant_id=%0d out_valid=%b in_ready=%b, expected sel=%b id=%0d valid=1",
                 i, sel, grant_id, out_valid, in_ready, exp_sel[i], i % 4);
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    int xfers = 0;
    apply_reset();
    in_valid = 4'b0011; in_last = 4'b0000; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      in_last = (k == 2) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++;
      if (sel !== 4'b0001 || in_ready !== 4'b0001 || out_valid !== 1'b1 || out_last !== (k == 2)) begin
        n_fail++;
        $display("FAIL lock_beat[%0d]: sel=%b in_ready=%b out_valid=%b out_last=%b, expected 0001/0001/1/%0d",
                 k, sel, in_ready, out_valid, out_last, k == 2);
      end
      if (in_ready[0] && in_valid[0]) xfers++;
      tick();
    end
    in_valid = 4'b0010; in_last = 4'b0000;
    #1;
    n_checks++;
    if (sel !== 4'b0010 || grant_id !== 2'd1 || xfers !== 3) begin
      n_fail++;
      $display("FAIL lock_handover: sel=%b grant_id=%0d xfers=%0d, expected 0010/1/3", sel, grant_id, xfers);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    apply_reset();
    in_valid = 4'b0011; in_last = 4'b0000; out_ready = 1'b1;
    tick();
    #1;
    if (in_ready[0] && in_valid[0]) accepted++;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (sel !== 4'b0001 || grant_id !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall[%0d]: sel=%b grant_id=%0d out_valid=%b in_ready=%b, expected 0001/0/1/0000",
                 i, sel, grant_id, out_valid, in_ready);
      end
      if (in_ready[0] && in_valid[0]) accepted++;
      tick();
    end
    out_ready = 1'b1; in_last = 4'b0001;
    #1;
    if (in_ready[0] && in_valid[0]) accepted++;
    tick();
    in_valid = 4'b0010; in_last = 4'b0000;
    #1;
    n_checks++;
    if (accepted !== 2 || sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_beats: accepted=%0d sel=%b, expected 2/0010", accepted, sel);
    end
  endtask

  task automatic test_sole_requester();
    apply_reset();
    in_valid = 4'b0100; in_last = 4'b0100; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (sel !== 4'b0100 || grant_id !== 2'd2 || out_valid !== 1'b1 || dut.ptr !== 2'd3) begin
        n_fail++;
        $display("FAIL sole_req[%0d]: sel=%b grant_id=%0d out_valid=%b ptr=%0d, expected 0100/2/1/3",
                 i, sel, grant_id, out_valid, dut.ptr);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    in_valid = 4'b0001; in_last = 4'b0000; out_ready = 1'b1;
    tick();
    n_checks++;
    if (sel !== 4'b0001 || dut.ptr !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_grant: sel=%b ptr=%0d, expected 0001/1", sel, dut.ptr);
    end
    tick();
    rst = 1'b1; in_valid = 4'b0011;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_accept: in_ready=%b out_valid=%b, expected 0000/0", in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (sel !== 4'b0000 || grant_id !== 2'd0 || dut.ptr !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: sel=%b grant_id=%0d ptr=%0d, expected 0000/0/0", sel, grant_id, dut.ptr);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (sel !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: sel=%b grant_id=%0d, expected 0001/0", sel, grant_id);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_sole_requester();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
